axi_pair_pack: RTL and testbench

- Upstream feeder for the two-operand adder stage.
- Accepts a serial byte stream over a valid/ready handshake and packs each two consecutive accepted bytes into one (a, b) operand pair. The first byte becomes a, the second becomes b.
- Pairs are queued in a small pair FIFO and presented on a valid/ready output that connects directly to the adder's din_a/din_b/din_valid/din_ready.

---
 rtl/axi_pair_pack.sv | 132 +++++++++++++
 tb/tb_axi_pair_pack.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_pair_pack.sv
// Packs a valid/ready byte stream into (a, b) operand pairs and queues them in a small pair FIFO.
// Optional PAIR_LAST_EN adds s_last: a packet-final byte landing in the a slot is pushed at once with b=0.
module axi_pair_pack #(
   parameter  int DW    = 8,
   parameter  int DEPTH = 2,
   localparam int LW    = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [DW-1:0] s_data,
   input  logic          s_valid,
`ifdef PAIR_LAST_EN
   input  logic          s_last,
`endif
   output logic          s_ready,
   output logic [DW-1:0] dout_a,
   output logic [DW-1:0] dout_b,
   output logic          dout_valid,
   input  logic          dout_ready,
   output logic [LW-1:0] level
);

   localparam int AW = LW - 1;

   typedef enum logic {
      WAIT_A = 1'b0,
      WAIT_B = 1'b1
   } state_t;

   state_t               state_q, state_d;
   logic [DW-1:0]        a_hold_q, a_hold_d;
   logic [2*DW-1:0]      mem_q [DEPTH];
   logic [2*DW-1:0]      mem_d [DEPTH];
   logic [LW-1:0]        wr_ptr_q, wr_ptr_d;
   logic [LW-1:0]        rd_ptr_q, rd_ptr_d;

   logic                 last_s;
   logic                 empty_s;
   logic                 full_s;
   logic                 accept_s;
   logic                 push_s;
   logic                 pop_s;
   logic [2*DW-1:0]      push_pair_s;
   logic [2*DW-1:0]      head_s;

   // Handshake decode and FIFO status; the extra pointer MSB separates full from empty.
   always_comb begin
`ifdef PAIR_LAST_EN
      last_s = s_last;
`else
      last_s = 1'b0;
`endif
      empty_s  = (wr_ptr_q == rd_ptr_q);
      full_s   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
      s_ready  = ((state_q == WAIT_A) && !last_s) || !full_s || dout_ready;
      accept_s = s_valid && s_ready;
      pop_s    = !empty_s && dout_ready;
   end

   // Pairing FSM and next-state of pointers and pair storage.
   always_comb begin
      state_d     = state_q;
      a_hold_d    = a_hold_q;
      push_s      = 1'b0;
      push_pair_s = {a_hold_q, s_data};
      mem_d       = mem_q;
      case (state_q)
         WAIT_A: begin
            if (accept_s && last_s) begin
               push_s      = 1'b1;
               push_pair_s = {s_data, {DW{1'b0}}};
            end else if (accept_s) begin
               a_hold_d = s_data;
               state_d  = WAIT_B;
            end else begin
               state_d = WAIT_A;
            end
         end
         WAIT_B: begin
            if (accept_s) begin
               push_s  = 1'b1;
               state_d = WAIT_A;
            end else begin
               state_d = WAIT_B;
            end
         end
         default: begin
            state_d = WAIT_A;
         end
      endcase

      if (push_s) begin
         mem_d[wr_ptr_q[AW-1:0]] = push_pair_s;
         wr_ptr_d                = wr_ptr_q + LW'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end

      if (pop_s) begin
         rd_ptr_d = rd_ptr_q + LW'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
   end

   // State, holding register, pointers and pair storage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= WAIT_A;
         a_hold_q <= {DW{1'b0}};
         wr_ptr_q <= {LW{1'b0}};
         rd_ptr_q <= {LW{1'b0}};
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= {(2*DW){1'b0}};
         end
      end else begin
         state_q  <= state_d;
         a_hold_q <= a_hold_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         mem_q    <= mem_d;
      end
   end

   // Head pair comes straight from storage flops, never from s_data.
   assign head_s     = mem_q[rd_ptr_q[AW-1:0]];
   assign dout_a     = head_s[2*DW-1:DW];
   assign dout_b     = head_s[DW-1:0];
   assign dout_valid = !empty_s;
   assign level      = wr_ptr_q - rd_ptr_q;

endmodule

// File: tb/tb_axi_pair_pack.sv
// Directed table, reset/last corner sequences and a randomised scoreboard run for axi_pair_pack.
module tb_axi_pair_pack;

   localparam int DW    = 8;
   localparam int DEPTH = 2;
   localparam int LW    = $clog2(DEPTH) + 1;

   logic          clk;
   logic          rst_n;
   logic [DW-1:0] s_data;
   logic          s_valid;
   logic          s_ready;
   logic [DW-1:0] dout_a;
   logic [DW-1:0] dout_b;
   logic          dout_valid;
   logic          dout_ready;
   logic [LW-1:0] level;
`ifdef PAIR_LAST_EN
   logic          s_last;
`endif

   int n_chk  = 0;
   int n_fail = 0;

   axi_pair_pack #(.DW(DW), .DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .s_data     (s_data),
      .s_valid    (s_valid),
`ifdef PAIR_LAST_EN
      .s_last     (s_last),
`endif
      .s_ready    (s_ready),
      .dout_a     (dout_a),
      .dout_b     (dout_b),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready),
      .level      (level)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       sv;
      logic [7:0] sd;
      logic       dr;
      logic       sr;
      logic       dv;
      logic       cd;
      logic [7:0] a;
      logic [7:0] b;
      logic [3:0] lvl;
   } vec_t;

   vec_t vecs [0:16];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic sv, input logic [7:0] sd, input logic dr, input logic last);
      @(negedge clk);
      s_valid    = sv;
      s_data     = sd;
      dout_ready = dr;
`ifdef PAIR_LAST_EN
      s_last     = last;
`else
      if (last) $display("note: s_last ignored in this build");
`endif
      #1;
   endtask

   task automatic chk_out(input string nm, input logic dv, input logic [7:0] a,
                          input logic [7:0] b, input logic [3:0] lvl);
      chk({nm, " dout_valid"}, {31'd0, dout_valid}, {31'd0, dv});
      chk({nm, " level"}, {{(32-LW){1'b0}}, level}, {28'd0, lvl});
      if (dv) begin
         chk({nm, " dout_a"}, {24'd0, dout_a}, {24'd0, a});
         chk({nm, " dout_b"}, {24'd0, dout_b}, {24'd0, b});
      end
   endtask

   initial begin
      logic [7:0] q [$];
      int         mlvl;
      logic       mst;
      logic       hold;
      logic       exp_sr;
      logic       acc;
      logic       pop;
      int         nacc;
      int         cyc;

      vecs[0]  = '{1'b1, 8'h11, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 4'd0};
      vecs[1]  = '{1'b1, 8'h22, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 4'd0};
      vecs[2]  = '{1'b1, 8'h33, 1'b1, 1'b1, 1'b1, 1'b1, 8'h11, 8'h22, 4'd1};
      vecs[3]  = '{1'b1, 8'h44, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 4'd0};
      vecs[4]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 8'h33, 8'h44, 4'd1};
      vecs[5]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 4'd0};
      vecs[6]  = '{1'b1, 8'h01, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 4'd0};
      vecs[7]  = '{1'b1, 8'h02, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 4'd0};
      vecs[8]  = '{1'b1, 8'h03, 1'b0, 1'b1, 1'b1, 1'b1, 8'h01, 8'h02, 4'd1};
      vecs[9]  = '{1'b1, 8'h04, 1'b0, 1'b1, 1'b1, 1'b1, 8'h01, 8'h02, 4'd1};
      vecs[10] = '{1'b1, 8'h05, 1'b0, 1'b1, 1'b1, 1'b1, 8'h01, 8'h02, 4'd2};
      vecs[11] = '{1'b1, 8'h06, 1'b0, 1'b0, 1'b1, 1'b1, 8'h01, 8'h02, 4'd2};
      vecs[12] = '{1'b1, 8'h06, 1'b0, 1'b0, 1'b1, 1'b1, 8'h01, 8'h02, 4'd2};
      vecs[13] = '{1'b1, 8'h06, 1'b1, 1'b1, 1'b1, 1'b1, 8'h01, 8'h02, 4'd2};
      vecs[14] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 8'h03, 8'h04, 4'd2};
      vecs[15] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 8'h05, 8'h06, 4'd1};
      vecs[16] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 4'd0};

      rst_n      = 1'b0;
      s_valid    = 1'b0;
      s_data     = 8'h00;
      dout_ready = 1'b0;
`ifdef PAIR_LAST_EN
      s_last     = 1'b0;
`endif
      #12;
      chk("reset dout_valid", {31'd0, dout_valid}, 32'd0);
      chk("reset dout_a", {24'd0, dout_a}, 32'd0);
      chk("reset dout_b", {24'd0, dout_b}, 32'd0);
      chk("reset level", {{(32-LW){1'b0}}, level}, 32'd0);
      chk("reset s_ready", {31'd0, s_ready}, 32'd1);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed table: streaming, back-pressure, full with push+pop.
      for (int i = 0; i <= 16; i++) begin
         drive(vecs[i].sv, vecs[i].sd, vecs[i].dr, 1'b0);
         chk($sformatf("vec%0d s_ready", i), {31'd0, s_ready}, {31'd0, vecs[i].sr});
         chk_out($sformatf("vec%0d", i), vecs[i].dv, vecs[i].a, vecs[i].b, vecs[i].lvl);
      end

      // Reset in the middle of a pair with one pair already queued.
      drive(1'b1, 8'h55, 1'b0, 1'b0);
      drive(1'b1, 8'h66, 1'b0, 1'b0);
      drive(1'b1, 8'hAA, 1'b0, 1'b0);
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      chk_out("pre-reset", 1'b1, 8'h55, 8'h66, 4'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst dout_valid", {31'd0, dout_valid}, 32'd0);
      chk("midrst dout_a", {24'd0, dout_a}, 32'd0);
      chk("midrst dout_b", {24'd0, dout_b}, 32'd0);
      chk("midrst level", {{(32-LW){1'b0}}, level}, 32'd0);
      chk("midrst s_ready", {31'd0, s_ready}, 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      drive(1'b1, 8'hBB, 1'b0, 1'b0);
      drive(1'b1, 8'hCC, 1'b0, 1'b0);
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      chk_out("post-reset pair", 1'b1, 8'hBB, 8'hCC, 4'd1);
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      chk_out("post-reset drained", 1'b0, 8'h00, 8'h00, 4'd0);

`ifdef PAIR_LAST_EN
      // Packet-final byte in the a slot is pushed alone with b=0.
      drive(1'b1, 8'h10, 1'b0, 1'b0);
      drive(1'b1, 8'h20, 1'b0, 1'b0);
      drive(1'b1, 8'h30, 1'b0, 1'b1);
      chk("last a-slot s_ready", {31'd0, s_ready}, 32'd1);
      drive(1'b1, 8'h40, 1'b0, 1'b0);
      chk("a while full s_ready", {31'd0, s_ready}, 32'd1);
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      chk_out("last q1", 1'b1, 8'h10, 8'h20, 4'd2);
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      drive(1'b1, 8'h50, 1'b0, 1'b0);
      chk_out("last q2", 1'b1, 8'h30, 8'h00, 4'd1);
      drive(1'b1, 8'h60, 1'b0, 1'b1);
      chk("last full s_ready", {31'd0, s_ready}, 32'd0);
      chk_out("last full", 1'b1, 8'h30, 8'h00, 4'd2);
      drive(1'b1, 8'h60, 1'b1, 1'b1);
      chk("last full pop s_ready", {31'd0, s_ready}, 32'd1);
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      chk_out("last q3", 1'b1, 8'h40, 8'h50, 4'd2);
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      chk_out("last q4", 1'b1, 8'h60, 8'h00, 4'd1);
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      chk_out("last drained", 1'b0, 8'h00, 8'h00, 4'd0);
`endif

      // Random handshakes against a pairing scoreboard.
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      mlvl = 0;
      mst  = 1'b0;
      hold = 1'b0;
      nacc = 0;
      cyc  = 0;
      while (nacc < 1000 && cyc < 8000) begin
         @(negedge clk);
         cyc++;
         if (!hold) begin
            s_valid = ($urandom_range(0, 3) != 0);
            s_data  = 8'($urandom);
         end else begin
            s_valid = 1'b1;
         end
         dout_ready = ($urandom_range(0, 2) != 0);
         #1;
         exp_sr = !mst || (mlvl < DEPTH) || dout_ready;
         chk("rand s_ready", {31'd0, s_ready}, {31'd0, exp_sr});
         chk("rand dout_valid", {31'd0, dout_valid}, {31'd0, mlvl != 0});
         chk("rand level", {{(32-LW){1'b0}}, level}, 32'(mlvl));
         acc = s_valid && exp_sr;
         pop = (mlvl != 0) && dout_ready;
         if (pop) begin
            if (q.size() >= 2) begin
               chk("rand dout_a", {24'd0, dout_a}, {24'd0, q[0]});
               chk("rand dout_b", {24'd0, dout_b}, {24'd0, q[1]});
               q.delete(0);
               q.delete(0);
            end else begin
               chk("rand scoreboard depth", 32'(q.size()), 32'd2);
            end
            mlvl--;
         end
         if (acc) begin
            q.push_back(s_data);
            nacc++;
            if (mst) mlvl++;
            mst = !mst;
         end
         hold = s_valid && !acc;
      end
      chk("rand byte budget", 32'(nacc), 32'd1000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
